// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_isa_pkg
// Brief    : MIPS opcode/funct constants and hazard-unit state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  localparam int STALL_CNT_W = 2;
  localparam int MD_CNT_W    = 7;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MD_STALL   = 2'd2
  } hz_state_e;

  function automatic logic is_hilo_read(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && ((fn == FN_MFHI) || (fn == FN_MFLO));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_v2_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_v2_if
// Brief    : Pipeline <-> hazard unit signal bundle. HAZARD_PERF_CNT_EN adds
//            the performance-counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_unit_v2_if #(
  parameter int REG_ADDR_W = 5
);
  logic [31:0]           fd_instruction;
  logic [REG_ADDR_W-1:0] dx_rt;
  logic                  dx_mem_read;
  logic                  md_start;
  logic                  jump;
  logic                  branch;
  logic                  equals_result;
  logic                  pc_write_en;
  logic                  fd_write_en;
  logic                  dx_bubble;
  logic                  fd_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           stall_cycles;
  logic [31:0]           flush_events;
`endif

  modport master (
    output fd_instruction, dx_rt, dx_mem_read, md_start, jump, branch, equals_result,
    input  pc_write_en, fd_write_en, dx_bubble, fd_flush
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_events
`endif
  );

  modport slave (
    input  fd_instruction, dx_rt, dx_mem_read, md_start, jump, branch, equals_result,
    output pc_write_en, fd_write_en, dx_bubble, fd_flush
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_events
`endif
  );

endinterface
`default_nettype wire

// File: rtl/hazard_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : hazard_down_counter
// Brief    : Loadable down-counter that saturates at zero; load wins over
//            decrement. next_o exposes the value the counter takes next edge.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_down_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule
`default_nettype wire

// File: rtl/hazard_unit_v2.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_v2
// Brief    : Load-use, HI/LO-use and control hazard unit for the 5-stage MIPS
//            pipeline. Optional macro HAZARD_PERF_CNT_EN adds stall/flush
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_v2
  import mips_isa_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int MD_LATENCY     = 32
) (
  input logic             clk,
  input logic             rst,
  hazard_unit_v2_if.slave hz
);

  localparam logic [STALL_CNT_W-1:0] c_LU_RELOAD = STALL_CNT_W'(LOAD_USE_STALL - 1);
  localparam logic [MD_CNT_W-1:0]    c_MD_RELOAD = MD_CNT_W'(MD_LATENCY - 1);
  localparam logic                   c_LU_MULTI  = (LOAD_USE_STALL > 1);

  hz_state_e             state_q;
  logic [5:0]            w_opcode;
  logic [5:0]            w_funct;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic                  w_uses_rs;
  logic                  w_uses_rt;
  logic                  w_reads_hilo;
  logic                  w_lu_haz;
  logic                  w_md_haz;
  logic                  w_stall_raw;
  logic                  w_stall;
  logic                  w_flush;
  logic                  w_stall_load;
  logic [STALL_CNT_W-1:0] w_stall_cnt;
  logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;
  logic [MD_CNT_W-1:0]    w_md_cnt;
  logic [MD_CNT_W-1:0]    w_md_cnt_nxt;
  logic                   w_unused_bits;

  assign w_opcode      = hz.fd_instruction[31:26];
  assign w_funct       = hz.fd_instruction[5:0];
  assign w_rs          = hz.fd_instruction[21 +: REG_ADDR_W];
  assign w_rt          = hz.fd_instruction[16 +: REG_ADDR_W];
  assign w_unused_bits = ^{hz.fd_instruction, w_stall_cnt_nxt};

  assign w_uses_rs    = !((w_opcode == OP_J) || (w_opcode == OP_JAL));
  assign w_reads_hilo = is_hilo_read(w_opcode, w_funct);
  assign w_uses_rt    = ((w_opcode == OP_RTYPE) && !w_reads_hilo) ||
                        (w_opcode == OP_BEQ) || (w_opcode == OP_BNE) ||
                        (w_opcode == OP_SW);

  // $0 never carries a real dependency, so a load into it cannot stall.
  assign w_lu_haz = hz.dx_mem_read && (hz.dx_rt != '0) &&
                    ((w_uses_rs && (hz.dx_rt == w_rs)) ||
                     (w_uses_rt && (hz.dx_rt == w_rt)));
  assign w_md_haz = w_reads_hilo && ((w_md_cnt != '0) || hz.md_start);

  assign w_stall_load = (state_q == ST_RUN) && w_lu_haz && c_LU_MULTI;

  hazard_down_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_stall_load),
    .load_val_i (c_LU_RELOAD),
    .dec_i      (state_q == ST_LOAD_STALL),
    .count_o    (w_stall_cnt),
    .next_o     (w_stall_cnt_nxt)
  );

  hazard_down_counter #(.WIDTH(MD_CNT_W)) u_md_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hz.md_start),
    .load_val_i (c_MD_RELOAD),
    .dec_i      (1'b1),
    .count_o    (w_md_cnt),
    .next_o     (w_md_cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_lu_haz) begin
            if (c_LU_MULTI) state_q <= ST_LOAD_STALL;
          end else if (w_md_haz && (w_md_cnt_nxt != '0)) begin
            state_q <= ST_MD_STALL;
          end
        end
        ST_LOAD_STALL: begin
          if (w_stall_cnt <= STALL_CNT_W'(1)) state_q <= ST_RUN;
        end
        ST_MD_STALL: begin
          if (w_md_cnt_nxt == '0) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_stall_raw = 1'b0;
    case (state_q)
      ST_RUN:        w_stall_raw = w_lu_haz || w_md_haz;
      ST_LOAD_STALL: w_stall_raw = 1'b1;
      ST_MD_STALL:   w_stall_raw = (w_md_cnt != '0);
      default:       w_stall_raw = 1'b0;
    endcase
  end

  // Stall outranks redirect: branch operands are stale while a load is pending.
  assign w_stall = w_stall_raw && !rst;
  assign w_flush = !rst && !w_stall && (hz.jump || (hz.branch && hz.equals_result));

  assign hz.pc_write_en = !w_stall;
  assign hz.fd_write_en = !w_stall;
  assign hz.dx_bubble   = w_stall;
  assign hz.fd_flush    = w_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (w_stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (w_flush && (flush_events_q != '1)) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit_v2
// Brief    : Directed plus randomized bench for hazard_unit_v2 against a
//            cycle-level reference model. HAZARD_PERF_CNT_EN checks counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_v2;
  import mips_isa_pkg::*;

  localparam int AW  = 5;
  localparam int LU  = 2;
  localparam int MDL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_v2_if #(.REG_ADDR_W(AW)) bus ();

  hazard_unit_v2 #(
    .REG_ADDR_W     (AW),
    .LOAD_USE_STALL (LU),
    .MD_LATENCY     (MDL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: remaining forced load bubbles, HI/LO busy cycles.
  int          m_load_left = 0;
  int          m_md_rem    = 0;
  bit          m_md_hold   = 0;
  logic [31:0] m_stalls    = '0;
  logic [31:0] m_flushes   = '0;
  bit          e_stall, e_flush, e_lu, e_mdh;

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [5:0] fn);
    return {op, rs, rt, 10'd0, fn};
  endfunction

  task automatic drive(input logic r, input logic [31:0] instr, input logic [4:0] drt,
                       input logic mr, input logic mds, input logic j,
                       input logic b, input logic eq);
    rst                = r;
    bus.fd_instruction = instr;
    bus.dx_rt          = drt;
    bus.dx_mem_read    = mr;
    bus.md_start       = mds;
    bus.jump           = j;
    bus.branch         = b;
    bus.equals_result  = eq;
  endtask

  task automatic compute_exp();
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    bit uses_rs, uses_rt, hilo;
    op      = bus.fd_instruction[31:26];
    fn      = bus.fd_instruction[5:0];
    rs      = bus.fd_instruction[25:21];
    rt      = bus.fd_instruction[20:16];
    hilo    = (op == 6'h00) && (fn == 6'h10 || fn == 6'h12);
    uses_rs = !(op == 6'h02 || op == 6'h03);
    uses_rt = (op == 6'h00 && !hilo) || op == 6'h04 || op == 6'h05 || op == 6'h2B;
    e_lu    = bus.dx_mem_read && bus.dx_rt != 0 &&
              ((uses_rs && bus.dx_rt == rs) || (uses_rt && bus.dx_rt == rt));
    e_mdh   = hilo && (m_md_rem != 0 || bus.md_start);
    if (rst)                  e_stall = 0;
    else if (m_load_left > 0) e_stall = 1;
    else if (m_md_hold)       e_stall = (m_md_rem != 0);
    else                      e_stall = e_lu || e_mdh;
    e_flush = !rst && !e_stall && (bus.jump || (bus.branch && bus.equals_result));
  endtask

  task automatic advance_model();
    int md_next;
    md_next = bus.md_start ? MDL - 1 : (m_md_rem > 0 ? m_md_rem - 1 : 0);
    if (rst) begin
      m_load_left = 0;
      m_md_hold   = 0;
      m_md_rem    = 0;
      m_stalls    = '0;
      m_flushes   = '0;
    end else begin
      if (m_load_left > 0)  m_load_left--;
      else if (m_md_hold)   m_md_hold = (md_next != 0);
      else if (e_lu)        m_load_left = LU - 1;
      else if (e_mdh)       m_md_hold = (md_next != 0);
      m_md_rem = md_next;
      if (e_stall && m_stalls != '1)  m_stalls++;
      if (e_flush && m_flushes != '1) m_flushes++;
    end
  endtask

  // One clock: check {pc_we, fd_we, bubble, flush} at negedge, then step model.
  task automatic cycle(input string tag, input bit use_const, input logic [3:0] cexp);
    logic [3:0] obs, exp;
    compute_exp();
    @(negedge clk);
    exp = use_const ? cexp : {!e_stall, !e_stall, e_stall, e_flush};
    obs = {bus.pc_write_en, bus.fd_write_en, bus.dx_bubble, bus.fd_flush};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    vectors++;
    assert (bus.stall_cycles === m_stalls) else begin
      miscompares++;
      $error("FAIL %s.stall_cycles observed=%0d expected=%0d", tag, bus.stall_cycles, m_stalls);
    end
    vectors++;
    assert (bus.flush_events === m_flushes) else begin
      miscompares++;
      $error("FAIL %s.flush_events observed=%0d expected=%0d", tag, bus.flush_events, m_flushes);
    end
`endif
    @(posedge clk);
    advance_model();
    #1;
  endtask

  initial begin
    logic [31:0] add_651, sw_52, add_000, jmp5, mflo, beq53, nop, rnd_ins;
    logic [5:0]  rop, rfn;
    add_651 = ins(OP_RTYPE, 5'd5, 5'd1, 6'h20);
    sw_52   = ins(OP_SW, 5'd2, 5'd5, 6'h00);
    add_000 = ins(OP_RTYPE, 5'd0, 5'd0, 6'h20);
    jmp5    = ins(OP_J, 5'd0, 5'd5, 6'h00);
    mflo    = ins(OP_RTYPE, 5'd0, 5'd0, FN_MFLO);
    beq53   = ins(OP_BEQ, 5'd5, 5'd3, 6'h00);
    nop     = 32'd0;

    drive(1, add_651, 5, 1, 1, 1, 1, 1);
    @(posedge clk); #1;
    cycle("reset_forced0", 1, 4'b1100);
    cycle("reset_forced1", 1, 4'b1100);

    // Load-use on rs: exactly two bubbles.
    drive(0, add_651, 5, 1, 0, 0, 0, 0); cycle("lu_rs_c0", 1, 4'b0010);
    drive(0, add_651, 5, 0, 0, 0, 0, 0); cycle("lu_rs_c1", 1, 4'b0010);
    cycle("lu_rs_c2", 1, 4'b1100);

    // Load-use through sw's rt field.
    drive(0, sw_52, 5, 1, 0, 0, 0, 0);   cycle("lu_rt_c0", 1, 4'b0010);
    drive(0, sw_52, 5, 0, 0, 0, 0, 0);   cycle("lu_rt_c1", 1, 4'b0010);
    cycle("lu_rt_c2", 1, 4'b1100);

    drive(0, add_000, 0, 1, 0, 0, 0, 0); cycle("lu_reg0", 1, 4'b1100);

    // Jump: no rt read, so no stall; flushes for one cycle.
    drive(0, jmp5, 5, 1, 0, 1, 0, 0);    cycle("jump_flush", 1, 4'b1101);
    drive(0, nop, 0, 0, 0, 0, 0, 0);     cycle("jump_after", 1, 4'b1100);

    // mult issue then mflo: stall cycles 1..3.
    drive(0, nop, 0, 0, 1, 0, 0, 0);     cycle("md_c0", 1, 4'b1100);
    drive(0, mflo, 0, 0, 0, 0, 0, 0);    cycle("md_c1", 1, 4'b0010);
    cycle("md_c2", 1, 4'b0010);
    cycle("md_c3", 1, 4'b0010);
    cycle("md_c4", 1, 4'b1100);

    // Taken beq behind a load-use: flush deferred past the stall.
    drive(0, beq53, 5, 1, 0, 0, 1, 1);   cycle("br_lu_c0", 1, 4'b0010);
    drive(0, beq53, 5, 0, 0, 0, 1, 1);   cycle("br_lu_c1", 1, 4'b0010);
    cycle("br_lu_c2", 1, 4'b1101);

    // Reset during the second stall cycle leaves no residual bubbles.
    drive(0, add_651, 5, 1, 0, 0, 0, 0); cycle("rst_mid_c0", 1, 4'b0010);
    drive(1, add_651, 5, 0, 0, 0, 0, 0); cycle("rst_mid_c1", 1, 4'b1100);
    drive(0, nop, 0, 0, 0, 0, 0, 0);     cycle("rst_mid_c2", 1, 4'b1100);
    cycle("rst_mid_c3", 1, 4'b1100);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(7))
        0: rop = OP_J;
        1: rop = OP_JAL;
        2: rop = OP_BEQ;
        3: rop = OP_BNE;
        4: rop = OP_SW;
        5: rop = 6'h23;
        default: rop = OP_RTYPE;
      endcase
      case ($urandom_range(3))
        0: rfn = FN_MFHI;
        1: rfn = FN_MFLO;
        2: rfn = 6'h08;
        default: rfn = 6'h20;
      endcase
      rnd_ins = ins(rop, 5'($urandom_range(3)), 5'($urandom_range(3)), rfn);
      drive(($urandom_range(99) < 3), rnd_ins, 5'($urandom_range(3)),
            ($urandom_range(99) < 40), ($urandom_range(99) < 8),
            ($urandom_range(99) < 10), ($urandom_range(99) < 20),
            1'($urandom_range(1)));
      cycle("random", 0, 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
